tube_par_responder: RTL
=======================

TUBE_PAR_RESPONDER -- requirements
Module: tube_par_responder

Interface
REQ-001 Parameter DEPTH, default 4, meaning entries per channel FIFO; must be a power of two, 2..16.
REQ-002 Parameter IRQ_CH, default 0, meaning the channel whose non-empty state drives p_irq_b.
REQ-003 Parameter NMI_CH, default 2, meaning the channel whose non-empty state drives p_nmi_b.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 p_addr  input  3  parasite tube register address; bit0=1 selects data, bit0=0 selects status; [2:1] selects channel 0..3.
REQ-007 p_cs_b  input  1  parasite chip select, active low.
REQ-008 p_rd_b  input  1  read strobe, active low, qualified by p_cs_b.
REQ-009 p_wr_b  input  1  write strobe, active low, qualified by p_cs_b.
REQ-010 p_dat_i  input  8  write data from initiator.
REQ-011 p_dat_o  output  8  read data to initiator.
REQ-012 p_dat_oe  output  1  high while a read access is active; initiator side enables its data input.
REQ-013 p_irq_b  output  1  interrupt, active low.
REQ-014 p_nmi_b  output  1  non-maskable interrupt, active low.

Function
REQ-015 Access definitions: rd_act = !p_cs_b & !p_rd_b; wr_act = !p_cs_b & !p_wr_b; both low at once is illegal, and the block then treats the access as a read only.
REQ-016 The block keeps registered copies rd_q and wr_q of rd_act and wr_act, plus the p_addr captured at access start.
REQ-017 Write start is wr_act & !wr_q: exactly one push per access, regardless of strobe length; p_dat_i is sampled that cycle.
REQ-018 Read end is !rd_act & rd_q: exactly one pop per data read, in the cycle after the strobe deasserts, using the captured address.
REQ-019 Write to a data address pushes p_dat_i into that channel FIFO if it is not full; if full, the data is dropped and that channel's overflow flag is set.
REQ-020 Write to a status address: bit0 is irq_en for the addressed channel; bit0 is used only when the channel equals IRQ_CH, and other bits are ignored.
REQ-021 Read of a data address: p_dat_o combinationally shows the FIFO head while rd_act; if the FIFO is empty it shows the last popped value of that channel and no pop occurs.
REQ-022 Read of a status address: p_dat_o = {not_empty, not_full, overflow, 4'b0, irq_en}, all for the addressed channel.
REQ-023 When a status read ends, that channel's overflow flag clears in the same cycle as read end.
REQ-024 If a new overflow coincides with a status-read end on the same channel, set wins.
REQ-025 p_dat_oe = rd_act; p_dat_o = 8'h00 whenever rd_act is low.
REQ-026 FIFO storage: read and write pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH; empty when pointers are equal; full when the low bits are equal and the MSBs differ.
REQ-027 A simultaneous push and pop on the same channel (write start and data-read end in the same cycle) both take effect: the count is unchanged.
REQ-028 In the REQ-027 case, if the channel is full the push still succeeds, because the pop frees the slot in the same cycle.
REQ-029 In the REQ-027 case, if the channel is empty the pop is ignored and the push succeeds.
REQ-030 p_irq_b = !(irq_en & not_empty[IRQ_CH]), registered, so it updates one cycle after a FIFO state change.
REQ-031 p_nmi_b = !not_empty[NMI_CH], registered with the same one-cycle latency as p_irq_b.
REQ-032 Channels are fully independent; an access touches only the addressed channel.

Reset
REQ-033 While reset is high: all pointers are 0, all FIFOs are empty, overflow flags are 0, irq_en is 0, rd_q and wr_q are 0, and last-popped values are 8'h00.
REQ-034 While reset is high: p_irq_b=1, p_nmi_b=1, p_dat_o=8'h00 and p_dat_oe=0, even if the strobes are active.
REQ-035 If reset asserts mid-access, the access is discarded: no push or pop, either during reset or after release.
REQ-036 After reset releases during a held strobe, the next rising edge of that strobe is treated as a new access.
REQ-037 FIFO RAM contents need no reset.

Verification
REQ-038 Loopback: write 8'hA5 then 8'h3C to addr 1, then read addr 1 twice -> p_dat_o reads 8'hA5 then 8'h3C; status read of addr 0 then returns 8'h40.
REQ-039 Full and overflow, DEPTH=4: five writes to addr 3 -> status of addr 2 reads 8'hA0 (not_empty, full, overflow); reading status again returns 8'h80; four data reads return the first four values.
REQ-040 Long strobe: hold wr_act for 10 cycles on addr 5 with 8'h11 -> exactly one entry is pushed; hold rd_act for 10 cycles -> exactly one pop, occurring one cycle after deassert.
REQ-041 Interrupts: write 8'h01 to addr 0, then write 8'h77 to addr 1 -> p_irq_b is low one cycle after the write start; reading addr 1 -> p_irq_b is high one cycle after the pop. Write to addr 5 -> p_nmi_b goes low the same way.
REQ-042 Simultaneous push and pop with DEPTH=4: fill channel 3 with 4 entries, then end a data read of addr 7 in the same cycle as a write start on addr 7 -> the count stays 4, overflow stays 0, and the data order is preserved.
REQ-043 Reset mid-access: assert reset for 2 cycles while wr_act is active on addr 1 -> FIFO 0 is empty afterwards, p_irq_b=1 and p_nmi_b=1, and status of addr 0 reads 8'h40.

Source files
------------

// File: rtl/tube_par_responder_if.sv
// Parasite-side tube bus: address, strobes and data between the initiator and the responder.
interface tube_par_responder_if;
  logic [2:0] p_addr;
  logic       p_cs_b;
  logic       p_rd_b;
  logic       p_wr_b;
  logic [7:0] p_dat_i;
  logic [7:0] p_dat_o;
  logic       p_dat_oe;
  logic       p_irq_b;
  logic       p_nmi_b;

  modport master (
    output p_addr, p_cs_b, p_rd_b, p_wr_b, p_dat_i,
    input  p_dat_o, p_dat_oe, p_irq_b, p_nmi_b
  );

  modport slave (
    input  p_addr, p_cs_b, p_rd_b, p_wr_b, p_dat_i,
    output p_dat_o, p_dat_oe, p_irq_b, p_nmi_b
  );
endinterface

// File: rtl/tube_par_responder.sv
// Four-channel tube responder: edge-detected strobes push/pop per-channel FIFOs,
// status registers report FIFO state, and two channels drive the interrupt lines.
module tube_par_responder #(
  parameter int DEPTH  = 4,
  parameter int IRQ_CH = 0,
  parameter int NMI_CH = 2
) (
  input  logic               clk,
  input  logic               reset,
  tube_par_responder_if.slave bus
);
  localparam int         AW      = $clog2(DEPTH);
  localparam int         PW      = AW + 1;
  localparam logic [1:0] IRQ_SEL = 2'(IRQ_CH);
  localparam logic [1:0] NMI_SEL = 2'(NMI_CH);

  logic                rd_act, wr_act, rd_start, wr_start, rd_end;
  logic                rd_q, rd_d, wr_q, wr_d, hold_q, hold_d;
  logic [2:0]          addr_q, addr_d;
  logic [3:0][PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]          ovf_q, ovf_d, not_empty, full;
  logic                irq_en_q, irq_en_d, irq_b_q, irq_b_d, nmi_b_q, nmi_b_d;
  logic [3:0][7:0]     last_q, last_d;
  logic [7:0]          mem_q [4][DEPTH];
  logic [1:0]          pop_ch, push_ch, rd_ch;
  logic                do_pop, do_push, wr_data;
  logic [7:0]          dat_o;

  // A simultaneous read and write strobe is resolved as a read.
  assign rd_act   = ~bus.p_cs_b & ~bus.p_rd_b;
  assign wr_act   = ~bus.p_cs_b & ~bus.p_wr_b & ~rd_act;
  assign rd_start = rd_act & ~rd_q & ~hold_q;
  assign wr_start = wr_act & ~wr_q & ~hold_q;
  assign rd_end   = ~rd_act & rd_q;

  // Per-channel FIFO occupancy flags
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      not_empty[c] = (wptr_q[c] != rptr_q[c]);
      full[c]      = (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]) && (wptr_q[c][AW] != rptr_q[c][AW]);
    end
  end

  // Next-state: access tracking, FIFO pointers, overflow, irq enable, interrupt lines
  always_comb begin
    // hold_q masks a strobe still held from before reset until the bus goes idle
    rd_d    = rd_act & ~hold_q;
    wr_d    = wr_act & ~hold_q;
    hold_d  = hold_q & (rd_act | wr_act);
    pop_ch  = addr_q[2:1];
    push_ch = bus.p_addr[2:1];
    do_pop  = rd_end & addr_q[0] & not_empty[pop_ch];
    wr_data = wr_start & bus.p_addr[0];
    // A pop on the same channel in this cycle frees the slot a full FIFO needs
    do_push = wr_data & (~full[push_ch] | (do_pop & (pop_ch == push_ch)));

    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;

    if (rd_start || wr_start) addr_d = bus.p_addr;
    else                      addr_d = addr_q;

    if (do_pop) begin
      rptr_d[pop_ch] = rptr_q[pop_ch] + PW'(1);
      last_d[pop_ch] = mem_q[pop_ch][rptr_q[pop_ch][AW-1:0]];
    end else begin
      rptr_d[pop_ch] = rptr_q[pop_ch];
    end

    if (do_push) wptr_d[push_ch] = wptr_q[push_ch] + PW'(1);
    else         wptr_d[push_ch] = wptr_q[push_ch];

    // Clear first so that a coinciding overflow on the same channel wins
    if (rd_end && !addr_q[0]) ovf_d[pop_ch] = 1'b0;
    else                      ovf_d[pop_ch] = ovf_q[pop_ch];
    if (wr_data && !do_push)  ovf_d[push_ch] = 1'b1;
    else                      ovf_d[push_ch] = ovf_d[push_ch];

    if (wr_start && !bus.p_addr[0] && (push_ch == IRQ_SEL)) irq_en_d = bus.p_dat_i[0];
    else                                                     irq_en_d = irq_en_q;

    irq_b_d = ~(irq_en_q & not_empty[IRQ_SEL]);
    nmi_b_d = ~not_empty[NMI_SEL];
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      hold_q   <= 1'b1;
      addr_q   <= 3'b000;
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 4'b0000;
      irq_en_q <= 1'b0;
      last_q   <= '0;
      irq_b_q  <= 1'b1;
      nmi_b_q  <= 1'b1;
    end else begin
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      hold_q   <= hold_d;
      addr_q   <= addr_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      last_q   <= last_d;
      irq_b_q  <= irq_b_d;
      nmi_b_q  <= nmi_b_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[push_ch][wptr_q[push_ch][AW-1:0]] <= bus.p_dat_i;
    end
  end

  // Read data mux: FIFO head (or last popped when empty) for data, flags for status
  always_comb begin
    rd_ch = bus.p_addr[2:1];
    if (reset || !rd_act) begin
      dat_o = 8'h00;
    end else if (bus.p_addr[0]) begin
      if (not_empty[rd_ch]) dat_o = mem_q[rd_ch][rptr_q[rd_ch][AW-1:0]];
      else                  dat_o = last_q[rd_ch];
    end else begin
      dat_o = {not_empty[rd_ch], ~full[rd_ch], ovf_q[rd_ch], 4'b0000,
               (rd_ch == IRQ_SEL) ? irq_en_q : 1'b0};
    end
  end

  assign bus.p_dat_o  = dat_o;
  assign bus.p_dat_oe = rd_act & ~reset;
  assign bus.p_irq_b  = irq_b_q;
  assign bus.p_nmi_b  = nmi_b_q;
endmodule
